key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/key_debounce.sv | 97 +++++++++
 tb/tb_key_debounce.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared constants for the key debouncer and the downstream pulse generator:
// FSM state encodings and the default debounce length.
package key_debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;  // 10 ms at 50 MHz
    localparam int CNT_W_DEF           = 19;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selectable
// so an idle input can be preloaded to its inactive level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Pushbutton debouncer: synchronizes an active-low key, accepts a level change
// only after DEBOUNCE_CYCLES stable samples, and emits registered press/release strobes.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key_n,
    output logic       trigger,
    output logic       pressed,
    output logic       released,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_n_sync;
    logic             key_s;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    // Reset value 1 keeps a held key looking released until it is re-debounced.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (key_n),
        .q       (key_n_sync)
    );

    assign key_s     = ~key_n_sync;
    assign dbg_state = state;

    // trigger and the strobes are all registered on the accepting edge so they rise together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            trigger  <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= 1'b0;
            released <= 1'b0;
            case (state)
                IDLE: begin
                    trigger <= 1'b0;
                    if (key_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    trigger <= 1'b0;
                    if (!key_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state   <= HELD;
                        trigger <= 1'b1;
                        pressed <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    trigger <= 1'b1;
                    if (!key_s) begin
                        state <= REL_WAIT;
                        cnt   <= '0;
                    end
                end
                REL_WAIT: begin
                    trigger <= 1'b1;
                    if (key_s) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        trigger  <= 1'b0;
                        released <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    trigger <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with a short debounce length; a stable-run reference
// model tracks the accepted key level and strobes every cycle.
module tb_key_debounce;

    localparam int D  = 4;
    localparam int CW = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       key_n;
    logic       trigger;
    logic       pressed;
    logic       released;
    logic [1:0] dbg_state;

    always #5 clock = ~clock;

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .key_n     (key_n),
        .trigger   (trigger),
        .pressed   (pressed),
        .released  (released),
        .dbg_state (dbg_state)
    );

    // Reference: a level change is accepted once D+1 consecutive synchronized
    // samples disagree with the current accepted level.
    logic m_s1, m_s2, m_level, m_pressed, m_released;
    int   m_run;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_s1       <= 1'b1;
            m_s2       <= 1'b1;
            m_level    <= 1'b0;
            m_run      <= 0;
            m_pressed  <= 1'b0;
            m_released <= 1'b0;
        end else begin
            m_s1       <= key_n;
            m_s2       <= m_s1;
            m_pressed  <= 1'b0;
            m_released <= 1'b0;
            if ((~m_s2) != m_level) begin
                if (m_run == D) begin
                    m_level <= ~m_level;
                    m_run   <= 0;
                    if (!m_level) m_pressed  <= 1'b1;
                    else          m_released <= 1'b1;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int n_press = 0;
    int n_rel   = 0;
    int n_trig  = 0;
    int p0, r0, t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n falling edges, comparing outputs against the model at each one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (reset_n) begin
                check("trigger_model", 32'(trigger), 32'(m_level));
                check("pressed_model", 32'(pressed), 32'(m_pressed));
                check("released_model", 32'(released), 32'(m_released));
                n_press += int'(pressed);
                n_rel   += int'(released);
                n_trig  += int'(trigger);
            end
        end
    endtask

    task automatic check_outputs_low(input string tag);
        check({tag, "_trigger"}, 32'(trigger), 0);
        check({tag, "_pressed"}, 32'(pressed), 0);
        check({tag, "_released"}, 32'(released), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        key_n   = 1'b1;
        repeat (3) @(negedge clock);
        check_outputs_low("reset");
        reset_n = 1'b1;
        step(5);

        // clean press: visible after edge 6, strobe lasts one cycle
        key_n = 1'b0;
        step(6);
        check("press_early_trigger", 32'(trigger), 0);
        step(1);
        check("press_trigger", 32'(trigger), 1);
        check("press_strobe", 32'(pressed), 1);
        step(1);
        check("press_strobe_end", 32'(pressed), 0);
        check("press_trigger_hold", 32'(trigger), 1);
        step(5);

        // clean release
        key_n = 1'b1;
        step(6);
        check("release_early", 32'(released), 0);
        step(1);
        check("release_trigger", 32'(trigger), 0);
        check("release_strobe", 32'(released), 1);
        step(1);
        check("release_strobe_end", 32'(released), 0);
        step(5);

        // bounce: 3 low, 1 high, then low for good
        p0 = n_press;
        key_n = 1'b0;
        step(3);
        key_n = 1'b1;
        step(1);
        key_n = 1'b0;
        step(6);
        check("bounce_no_strobe", 32'(n_press - p0), 0);
        step(1);
        check("bounce_press", 32'(pressed), 1);
        step(3);
        check("bounce_one_press", 32'(n_press - p0), 1);

        // short release glitch while held
        r0 = n_rel;
        key_n = 1'b1;
        step(2);
        key_n = 1'b0;
        step(12);
        check("glitch_trigger", 32'(trigger), 1);
        check("glitch_no_release", 32'(n_rel - r0), 0);

        // reset during PRESS_WAIT
        key_n = 1'b1;
        step(12);
        key_n = 1'b0;
        step(4);
        check("pw_state", 32'(dbg_state), 1);
        #2 reset_n = 1'b0;
        #1 check_outputs_low("rst_pw");
        @(negedge clock);
        reset_n = 1'b1;
        p0 = n_press;
        step(6);
        check("rst_pw_no_early", 32'(n_press - p0), 0);
        step(1);
        check("rst_pw_press", 32'(pressed), 1);
        check("rst_pw_trigger", 32'(trigger), 1);
        step(3);
        check("held_state", 32'(dbg_state), 2);

        // reset while HELD, key still down
        r0 = n_rel;
        #2 reset_n = 1'b0;
        #1 check_outputs_low("rst_held");
        @(negedge clock);
        reset_n = 1'b1;
        step(6);
        check("rst_held_trigger_low", 32'(trigger), 0);
        step(1);
        check("rst_held_press", 32'(pressed), 1);
        check("rst_held_no_release", 32'(n_rel - r0), 0);

        // long hold from idle
        key_n = 1'b1;
        step(12);
        p0 = n_press;
        r0 = n_rel;
        t0 = n_trig;
        key_n = 1'b0;
        step(1000);
        check("hold_one_press", 32'(n_press - p0), 1);
        check("hold_no_release", 32'(n_rel - r0), 0);
        check("hold_trigger_cycles", 32'(n_trig - t0), 1000 - (D + 2));

        // randomized runs with occasional asynchronous resets
        repeat (400) begin
            key_n = 1'($urandom_range(0, 1));
            step($urandom_range(1, 2 * D + 1));
            if ($urandom_range(0, 39) == 0) begin
                #2 reset_n = 1'b0;
                #1 check_outputs_low("rand_rst");
                @(negedge clock);
                reset_n = 1'b1;
            end
        end
        key_n = 1'b1;
        step(20);
        check("final_idle", 32'(dbg_state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
